// File: rtl/cpu16_loader.sv
// cpu16 program loader: encodes instructions into 16-bit IR words and writes
// them big-endian into byte-wide instruction memory while stalling fetch.
module cpu16_loader #(
    parameter int AW = 6
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          start,
    input  logic          finish,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    op,
    input  logic [3:0]    dest,
    input  logic [3:0]    src,
    input  logic          raw,
    input  logic [15:0]   raw_word,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic [AW-1:0] count,
    output logic          full,
    output logic          hold
);

    localparam int PW = AW + 1;
    localparam logic [AW-1:0] CAP = AW'(2 ** (AW - 1));

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WR_HI,
        WR_LO
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [7:0]    word_lo;
    logic          pend_fin;
    logic [3:0]    func;
    logic [15:0]   enc;
    logic [AW-1:0] count_nxt;
    logic          accept;

    always_comb begin
        func = 4'b1110;
        case (op)
            2'd0:    func = 4'b1010;
            2'd1:    func = 4'b0010;
            2'd2:    func = 4'b1100;
            default: func = 4'b1110;
        endcase
        enc = raw ? raw_word : {4'b0000, dest, func, src};
    end

    assign in_ready  = (state == LOAD) && !full;
    // Pointer MSB only sets once capacity is reached, so it doubles as a wrap guard.
    assign accept    = in_valid && in_ready && !ptr[PW-1];
    assign hold      = (state != IDLE);
    assign count_nxt = count + AW'(1);

    always_ff @(posedge ck) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            word_lo   <= '0;
            pend_fin  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            full      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        ptr   <= '0;
                        count <= '0;
                        full  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        word_lo   <= enc[7:0];
                        mem_we    <= 1'b1;
                        mem_addr  <= ptr[AW-1:0];
                        mem_wdata <= enc[15:8];
                        state     <= WR_HI;
                    end else if (finish) begin
                        state <= IDLE;
                    end else if (start) begin
                        ptr   <= '0;
                        count <= '0;
                        full  <= 1'b0;
                    end
                end
                WR_HI: begin
                    mem_addr  <= ptr[AW-1:0] + AW'(1);
                    mem_wdata <= word_lo;
                    if (finish) pend_fin <= 1'b1;
                    state <= WR_LO;
                end
                WR_LO: begin
                    mem_we   <= 1'b0;
                    ptr      <= ptr + PW'(2);
                    count    <= count_nxt;
                    if (count_nxt == CAP) full <= 1'b1;
                    pend_fin <= 1'b0;
                    state    <= (pend_fin || finish) ? IDLE : LOAD;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu16_loader.sv
// Scoreboard bench for cpu16_loader: AW=6 instance for encoding/session flow,
// AW=4 instance for capacity limits.
module tb_cpu16_loader;

    logic ck = 1'b0;
    always #5 ck = ~ck;

    logic        rst_a, rst_b, start_a, start_b, finish_a, finish_b;
    logic        in_valid_a, in_valid_b, raw;
    logic [1:0]  op;
    logic [3:0]  dest, src;
    logic [15:0] raw_word;

    logic       rdy_a, we_a, full_a, hold_a;
    logic [5:0] addr_a, cnt_a;
    logic [7:0] wd_a;
    logic       rdy_b, we_b, full_b, hold_b;
    logic [3:0] addr_b, cnt_b;
    logic [7:0] wd_b;

    cpu16_loader #(.AW(6)) dut_a (
        .ck(ck), .rst(rst_a), .start(start_a), .finish(finish_a),
        .in_valid(in_valid_a), .in_ready(rdy_a), .op(op), .dest(dest), .src(src),
        .raw(raw), .raw_word(raw_word), .mem_we(we_a), .mem_addr(addr_a),
        .mem_wdata(wd_a), .count(cnt_a), .full(full_a), .hold(hold_a)
    );

    cpu16_loader #(.AW(4)) dut_b (
        .ck(ck), .rst(rst_b), .start(start_b), .finish(finish_b),
        .in_valid(in_valid_b), .in_ready(rdy_b), .op(op), .dest(dest), .src(src),
        .raw(raw), .raw_word(raw_word), .mem_we(we_b), .mem_addr(addr_b),
        .mem_wdata(wd_b), .count(cnt_b), .full(full_b), .hold(hold_b)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t qa[$];
    wr_t qb[$];
    int  errors = 0;
    int  checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge ck) begin
        wr_t e;
        if (we_a) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_a_unexpected: got addr %0h data %0h expected no write", addr_a, wd_a);
            end else begin
                e = qa.pop_front();
                chk("wr_a_addr", {26'd0, addr_a}, {24'd0, e.addr});
                chk("wr_a_data", {24'd0, wd_a}, {24'd0, e.data});
            end
        end
        if (we_b) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_b_unexpected: got addr %0h data %0h expected no write", addr_b, wd_b);
            end else begin
                e = qb.pop_front();
                chk("wr_b_addr", {28'd0, addr_b}, {24'd0, e.addr});
                chk("wr_b_data", {24'd0, wd_b}, {24'd0, e.data});
            end
        end
    end

    // Offers one instruction, pushes the expected byte writes, returns #1 after the accept edge.
    task automatic send(input bit b, input logic r, input logic [1:0] o, input logic [3:0] d,
                        input logic [3:0] s, input logic [15:0] w, input logic [15:0] exp,
                        input logic [7:0] addr, input int nbytes);
        int  n = 0;
        wr_t e;
        raw = r; op = o; dest = d; src = s; raw_word = w;
        if (b) in_valid_b = 1'b1; else in_valid_a = 1'b1;
        while (!(b ? rdy_b : rdy_a) && n < 40) begin
            @(posedge ck); #1;
            n++;
        end
        if (n >= 40) begin
            chk("ready_timeout", 32'(n), 32'd0);
            in_valid_a = 1'b0;
            in_valid_b = 1'b0;
            return;
        end
        e.addr = addr; e.data = exp[15:8];
        if (b) qb.push_back(e); else qa.push_back(e);
        if (nbytes == 2) begin
            e.addr = addr + 8'd1; e.data = exp[7:0];
            if (b) qb.push_back(e); else qa.push_back(e);
        end
        @(posedge ck); #1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
    endtask

    task automatic pulse_start(input bit b);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge ck); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge ck);
        #1;
    endtask

    logic [15:0] tblb [8] = '{16'h1234, 16'hABCD, 16'h0F0F, 16'hF00D,
                               16'h5A5A, 16'hC3C3, 16'h7E81, 16'h9966};

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1; rst_b = 1; start_a = 0; start_b = 0; finish_a = 0; finish_b = 0;
        in_valid_a = 0; in_valid_b = 0; raw = 0; op = 0; dest = 0; src = 0; raw_word = 0;
        cycles(2);
        rst_a = 0; rst_b = 0;

        chk("rst_ready", {31'd0, rdy_a}, 32'd0);
        chk("rst_hold", {31'd0, hold_a}, 32'd0);
        chk("rst_we", {31'd0, we_a}, 32'd0);
        chk("rst_count", {26'd0, cnt_a}, 32'd0);
        chk("rst_full", {31'd0, full_a}, 32'd0);
        chk("rst_addr", {26'd0, addr_a}, 32'd0);
        chk("rst_wdata", {24'd0, wd_a}, 32'd0);

        // ADD R0,R1 and handshake latency
        pulse_start(0);
        chk("start_hold", {31'd0, hold_a}, 32'd1);
        chk("start_ready", {31'd0, rdy_a}, 32'd1);
        send(0, 0, 2'd0, 4'd0, 4'd1, 16'h0, 16'h00A1, 8'd0, 2);
        chk("rdy_k", {31'd0, rdy_a}, 32'd0);
        cycles(1);
        chk("rdy_k1", {31'd0, rdy_a}, 32'd0);
        cycles(1);
        chk("rdy_k2", {31'd0, rdy_a}, 32'd1);
        chk("count_1", {26'd0, cnt_a}, 32'd1);

        // restart in LOAD, then SUB/AND/OR back to back
        pulse_start(0);
        chk("restart_count", {26'd0, cnt_a}, 32'd0);
        send(0, 0, 2'd1, 4'd3, 4'd5, 16'h0, 16'h0325, 8'd0, 2);
        send(0, 0, 2'd2, 4'd2, 4'd15, 16'h0, 16'h02CF, 8'd2, 2);
        send(0, 0, 2'd3, 4'd7, 4'd4, 16'h0, 16'h07E4, 8'd4, 2);
        cycles(2);
        chk("count_3", {26'd0, cnt_a}, 32'd3);

        // raw word after two encoded words
        pulse_start(0);
        send(0, 0, 2'd0, 4'd1, 4'd2, 16'h0, 16'h01A2, 8'd0, 2);
        send(0, 0, 2'd1, 4'd4, 4'd6, 16'h0, 16'h0426, 8'd2, 2);
        send(0, 1, 2'd3, 4'd15, 4'd15, 16'hBEEF, 16'hBEEF, 8'd4, 2);
        cycles(2);
        chk("raw_count", {26'd0, cnt_a}, 32'd3);

        // FINISH in WR_HI, START in WR_LO
        send(0, 0, 2'd3, 4'd1, 4'd1, 16'h0, 16'h01E1, 8'd6, 2);
        finish_a = 1;
        cycles(1);
        finish_a = 0;
        start_a = 1;
        cycles(1);
        start_a = 0;
        chk("fin_hold", {31'd0, hold_a}, 32'd0);
        chk("fin_ready", {31'd0, rdy_a}, 32'd0);
        chk("fin_count", {26'd0, cnt_a}, 32'd4);
        cycles(3);
        chk("fin_stay_idle", {31'd0, hold_a}, 32'd0);

        // RST during WR_HI aborts the word
        pulse_start(0);
        chk("s5_count", {26'd0, cnt_a}, 32'd0);
        send(0, 0, 2'd0, 4'd5, 4'd6, 16'h0, 16'h05A6, 8'd0, 1);
        rst_a = 1;
        cycles(1);
        rst_a = 0;
        chk("abort_we", {31'd0, we_a}, 32'd0);
        chk("abort_count", {26'd0, cnt_a}, 32'd0);
        chk("abort_hold", {31'd0, hold_a}, 32'd0);
        chk("abort_ready", {31'd0, rdy_a}, 32'd0);
        cycles(4);

        // AW=4 capacity: 8 words fit, 9th refused
        pulse_start(1);
        for (int i = 0; i < 8; i++)
            send(1, 1, 2'd0, 4'd0, 4'd0, tblb[i], tblb[i], 8'(2 * i), 2);
        cycles(2);
        chk("b_full", {31'd0, full_b}, 32'd1);
        chk("b_count", {28'd0, cnt_b}, 32'd8);
        chk("b_ready_full", {31'd0, rdy_b}, 32'd0);
        raw = 1; raw_word = 16'hDEAD;
        in_valid_b = 1;
        cycles(6);
        chk("b_ready_held", {31'd0, rdy_b}, 32'd0);
        chk("b_count_held", {28'd0, cnt_b}, 32'd8);
        in_valid_b = 0;
        pulse_start(1);
        chk("b_full_clr", {31'd0, full_b}, 32'd0);
        chk("b_count_clr", {28'd0, cnt_b}, 32'd0);
        chk("b_ready_clr", {31'd0, rdy_b}, 32'd1);
        finish_b = 1;
        cycles(1);
        finish_b = 0;
        chk("b_idle_hold", {31'd0, hold_b}, 32'd0);

        cycles(3);
        chk("qa_drained", 32'(qa.size()), 32'd0);
        chk("qb_drained", 32'(qb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
